// File: rtl/dot_prod_acc.sv
// dot_prod_acc: pipelined fixed-point dot-product engine.
//
// Each accepted beat carries LANES signed operand pairs. The pairs are
// multiplied into a product register stage (P), then summed into a
// full-precision accumulator one edge later. After VEC_LEN products have been
// accumulated, the sum is quantized once to a BIT_NUM-bit signed result with
// selectable rounding and optional saturation.
//
// Ports:
//   clk, srst_n            clock, synchronous active-low reset
//   in_valid / in_ready    operand beat handshake (in_ready only in ACC)
//   in_a, in_b             LANES packed signed operands, lane i at [i*BIT_NUM +: BIT_NUM]
//   round_mode             0 = floor with +1 when acc negative, 1 = round-half-up
//   sat_en                 1 = clamp to signed BIT_NUM range, 0 = wrap
//   out_valid / out_ready  result handshake
//   out_data               quantized signed result
//   out_sat                quantized value fell outside BIT_NUM signed range

// One lane: registered signed product, loaded when en is high.
module dot_prod_lane #(
  parameter int BIT_NUM = 18
) (
  input  logic                   clk,
  input  logic                   srst_n,
  input  logic                   en,
  input  logic [BIT_NUM-1:0]     a,
  input  logic [BIT_NUM-1:0]     b,
  output logic [2*BIT_NUM-1:0]   prod_q
);
  logic [2*BIT_NUM-1:0] prod_d;

  always_comb begin
    prod_d = prod_q;
    if (en) prod_d = $signed(a) * $signed(b);
  end

  always_ff @(posedge clk) begin
    if (!srst_n) prod_q <= '0;
    else         prod_q <= prod_d;
  end
endmodule

module dot_prod_acc #(
  parameter int BIT_NUM  = 18,
  parameter int FRAC_NUM = 9,
  parameter int LANES    = 2,
  parameter int VEC_LEN  = 8
) (
  input  logic                       clk,
  input  logic                       srst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*BIT_NUM-1:0]   in_a,
  input  logic [LANES*BIT_NUM-1:0]   in_b,
  input  logic                       round_mode,
  input  logic                       sat_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BIT_NUM-1:0]         out_data,
  output logic                       out_sat
);
  localparam int BEATS  = VEC_LEN / LANES;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PROD_W = 2 * BIT_NUM;
  localparam int ACC_W  = 2 * BIT_NUM + $clog2(VEC_LEN) + 1;
  localparam int QW     = ACC_W - FRAC_NUM;

  // Half an LSB of the result, added before the shift in round-half-up mode.
  localparam logic signed [ACC_W-1:0] RND   = ACC_W'((2 ** FRAC_NUM) / 2);
  localparam logic signed [QW-1:0]    Q_MAX = QW'({1'b0, {(BIT_NUM-1){1'b1}}});
  localparam logic signed [QW-1:0]    Q_MIN = ~Q_MAX;

  typedef enum logic [1:0] {
    S_ACC   = 2'd0,
    S_DRAIN = 2'd1,
    S_OUT   = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      p_vld_q, p_vld_d;
  logic                      mode_q, mode_d;
  logic                      sat_en_q, sat_en_d;
  logic [BIT_NUM-1:0]        out_data_q, out_data_d;
  logic                      out_sat_q, out_sat_d;

  logic                      accept;
  logic [LANES-1:0][PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]   psum;
  logic signed [ACC_W-1:0]   acc_rnd;
  logic signed [QW-1:0]      q;
  logic                      sat_hi, sat_lo;
  logic [BIT_NUM-1:0]        q_data;

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign accept    = in_valid && (state_q == S_ACC);

  // Stage P: one registered multiplier per lane.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    dot_prod_lane #(.BIT_NUM(BIT_NUM)) u_lane (
      .clk    (clk),
      .srst_n (srst_n),
      .en     (accept),
      .a      (in_a[gi*BIT_NUM +: BIT_NUM]),
      .b      (in_b[gi*BIT_NUM +: BIT_NUM]),
      .prod_q (prod[gi])
    );
  end

  // Sign-extended sum of the registered lane products.
  always_comb begin
    psum = '0;
    for (int i = 0; i < LANES; i++) psum = psum + ACC_W'($signed(prod[i]));
  end

  // Quantization of the settled accumulator.
  always_comb begin
    acc_rnd = mode_q ? (acc_q + RND) : acc_q;
    q       = QW'(acc_rnd >>> FRAC_NUM);
    // Legacy mode bumps negative sums by one LSB after flooring.
    if (!mode_q && acc_q[ACC_W-1]) q = q + QW'(1);
    sat_hi = (q > Q_MAX);
    sat_lo = (q < Q_MIN);
    q_data = q[BIT_NUM-1:0];
    if (sat_en_q && sat_hi) q_data = Q_MAX[BIT_NUM-1:0];
    if (sat_en_q && sat_lo) q_data = Q_MIN[BIT_NUM-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    p_vld_d    = accept;
    mode_d     = mode_q;
    sat_en_d   = sat_en_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    if (p_vld_q) acc_d = acc_q + psum;

    case (state_q)
      S_ACC: begin
        if (in_valid) begin
          if (cnt_q == '0) begin
            mode_d   = round_mode;
            sat_en_d = sat_en;
          end
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Entered with the last product still in stage P; wait one edge for it
        // to land in acc, then register the quantized result.
        if (!p_vld_q) begin
          out_data_d = q_data;
          out_sat_d  = sat_hi || sat_lo;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          state_d = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q    <= S_ACC;
      cnt_q      <= '0;
      acc_q      <= '0;
      p_vld_q    <= 1'b0;
      mode_q     <= 1'b0;
      sat_en_q   <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      p_vld_q    <= p_vld_d;
      mode_q     <= mode_d;
      sat_en_q   <= sat_en_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end
endmodule

// File: tb/tb_dot_prod_acc.sv
// Directed bench for dot_prod_acc with VEC_LEN=4, LANES=2 (two beats per vector).
module tb_dot_prod_acc;
  localparam int BIT_NUM  = 18;
  localparam int FRAC_NUM = 9;
  localparam int LANES    = 2;
  localparam int VEC_LEN  = 4;

  logic                         clk = 1'b0;
  logic                         srst_n;
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES*BIT_NUM-1:0]     in_a;
  logic [LANES*BIT_NUM-1:0]     in_b;
  logic                         round_mode;
  logic                         sat_en;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [BIT_NUM-1:0]    out_data;
  logic                         out_sat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dot_prod_acc #(
    .BIT_NUM  (BIT_NUM),
    .FRAC_NUM (FRAC_NUM),
    .LANES    (LANES),
    .VEC_LEN  (VEC_LEN)
  ) dut (
    .clk        (clk),
    .srst_n     (srst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .round_mode (round_mode),
    .sat_en     (sat_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one beat and hold it until accepted (bounded).
  task automatic beat(input int a0, input int a1, input int b0, input int b1,
                      input logic rm, input logic se);
    int n;
    n = 0;
    in_a       = {BIT_NUM'(a1), BIT_NUM'(a0)};
    in_b       = {BIT_NUM'(b1), BIT_NUM'(b0)};
    round_mode = rm;
    sat_en     = se;
    in_valid   = 1'b1;
    while (!in_ready && n < 50) begin tick(); n++; end
    check("beat_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for a result (bounded), check it, then complete the handshake.
  task automatic result(input string tag, input int exp_d, input int exp_s);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_sat"}, out_sat, exp_s);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    srst_n     = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    round_mode = 1'b0;
    sat_en     = 1'b0;
    out_ready  = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    srst_n = 1'b1;
    tick();

    // 4 x (1.0 * 1.0) = 4.0 -> 2048, with latency check.
    beat(512, 512, 512, 512, 1'b0, 1'b0);
    beat(512, 512, 512, 512, 1'b0, 1'b0);
    check("lat_k", out_valid, 0);
    tick();
    check("lat_k1", out_valid, 0);
    tick();
    check("lat_k2", out_valid, 1);
    result("ones", 2048, 0);

    // acc = -524288: legacy mode adds one, half-up stays at -1024.
    beat(512, 512, -256, -256, 1'b0, 1'b0);
    beat(512, 512, -256, -256, 1'b0, 1'b0);
    result("neg_m0", -1023, 0);
    beat(512, 512, -256, -256, 1'b1, 1'b0);
    beat(512, 512, -256, -256, 1'b1, 1'b0);
    result("neg_m1", -1024, 0);

    // acc = 256 (exactly half an LSB); mode sampled on the first beat only.
    beat(0, 1, 0, 256, 1'b1, 1'b0);
    beat(0, 0, 0, 0, 1'b0, 1'b0);
    result("half_m1", 1, 0);
    beat(0, 1, 0, 256, 1'b0, 1'b0);
    beat(0, 0, 0, 0, 1'b1, 1'b0);
    result("half_m0", 0, 0);

    // Positive overflow: q = 2^27.
    beat(-131072, -131072, -131072, -131072, 1'b0, 1'b1);
    beat(-131072, -131072, -131072, -131072, 1'b0, 1'b1);
    result("satp_on", 131071, 1);
    beat(-131072, -131072, -131072, -131072, 1'b0, 1'b0);
    beat(-131072, -131072, -131072, -131072, 1'b0, 1'b0);
    result("satp_off", 0, 1);

    // Negative overflow: q = -2^27 + 1024 + 1 (legacy), wraps to 1025.
    beat(-131072, -131072, 131071, 131071, 1'b0, 1'b1);
    beat(-131072, -131072, 131071, 131071, 1'b0, 1'b1);
    result("satn_on", -131072, 1);
    beat(-131072, -131072, 131071, 131071, 1'b0, 1'b0);
    beat(-131072, -131072, 131071, 131071, 1'b0, 1'b0);
    result("satn_off", 1025, 1);

    // Back-pressure with junk beats offered during OUT.
    beat(512, 512, 512, 512, 1'b0, 1'b0);
    beat(512, 512, 512, 512, 1'b0, 1'b0);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 50) begin tick(); n++; end
    end
    in_a     = {BIT_NUM'(1000), BIT_NUM'(1000)};
    in_b     = {BIT_NUM'(1000), BIT_NUM'(1000)};
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 2048);
      check("stall_in_ready", in_ready, 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_release_ready", in_ready, 1);
    check("stall_release_valid", out_valid, 0);
    beat(512, 512, -256, -256, 1'b1, 1'b0);
    beat(512, 512, -256, -256, 1'b1, 1'b0);
    result("after_stall", -1024, 0);

    // Reset one cycle after the first beat of a vector.
    beat(512, 512, 512, 512, 1'b0, 1'b0);
    srst_n = 1'b0;
    tick();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_sat", out_sat, 0);
    check("mid_rst_in_ready", in_ready, 1);
    srst_n = 1'b1;
    tick();
    beat(512, 512, -256, -256, 1'b1, 1'b0);
    beat(512, 512, -256, -256, 1'b1, 1'b0);
    result("after_rst", -1024, 0);

    // Random idle gaps between beats give the same results.
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 3)) tick();
      beat(512, 512, 512, 512, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
      beat(512, 512, 512, 512, 1'b0, 1'b0);
      result("gaps_pos", 2048, 0);
      repeat ($urandom_range(0, 3)) tick();
      beat(512, 512, -256, -256, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
      beat(512, 512, -256, -256, 1'b0, 1'b0);
      result("gaps_neg", -1023, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
